// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core: exception codes, default
// address map and the fetch-path selector encoding.
package mips_pkg;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_NONE = 5'd0;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO     = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI     = 32'h0000_6FFC;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,
    SEL_EXC   = 3'd1,
    SEL_HOLD  = 3'd2,
    SEL_REDIR = 3'd3,
    SEL_PEND  = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a branch/ERET redirect that arrived while the
// fetch stage was stalled.
module pc_redirect_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic         consume,
  input  logic [W-1:0] load_target,
  output logic         pend_valid,
  output logic [W-1:0] pend_target
);

  logic         valid_r;
  logic [W-1:0] target_r;

  // Clear (exception or fresh redirect) outranks a load; a newer load overwrites.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r  <= 1'b0;
      target_r <= {W{1'b0}};
    end else if (clear) begin
      valid_r  <= 1'b0;
    end else if (load) begin
      valid_r  <= 1'b1;
      target_r <= load_target;
    end else if (consume) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign pend_valid  = valid_r;
  assign pend_target = target_r;

endmodule

// File: rtl/pc_unit.sv
// Fetch-address register: sequential +4, branch/ERET redirects (buffered
// across stalls), exception vector, and AdEL detection on the fetch address.
module pc_unit
  import mips_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VEC = W'(DEF_RESET_VEC),
  parameter logic [W-1:0] EXC_VEC   = W'(DEF_EXC_VEC),
  parameter logic [W-1:0] IM_LO     = W'(DEF_IM_LO),
  parameter logic [W-1:0] IM_HI     = W'(DEF_IM_HI)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         req,
  input  logic         eret,
  input  logic [W-1:0] epc,
  input  logic         br_valid,
  input  logic [W-1:0] br_target,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus8,
  output logic         pend_valid,
  output logic         fetch_exc,
  output logic [4:0]   exc_code
);

  localparam logic [W-1:0] STEP4 = W'(INSN_BYTES);
  localparam logic [W-1:0] STEP8 = W'(2 * INSN_BYTES);

  function automatic logic addr_bad(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
  endfunction

  logic [W-1:0] pc_r;
  logic [W-1:0] pc_plus8_r;
  logic         fetch_exc_r;
  logic [4:0]   exc_code_r;

  logic [W-1:0] rsel_s;
  logic         rvalid_s;
  logic [W-1:0] pc_plus4_s;
  logic [W-1:0] pc_next_s;
  logic         pend_valid_s;
  logic [W-1:0] pend_target_s;
  logic         load_s;
  logic         clear_s;
  logic         consume_s;
  logic         next_bad_s;
  pc_sel_e      sel_s;

  assign rsel_s     = eret ? epc : br_target;
  assign rvalid_s   = eret | br_valid;
  assign pc_plus4_s = pc_r + STEP4;

  // Priority select: exception, stall, fresh redirect, buffered redirect, +4.
  always_comb begin
    sel_s = SEL_SEQ;
    if (req) begin
      sel_s = SEL_EXC;
    end else if (stall) begin
      sel_s = SEL_HOLD;
    end else if (rvalid_s) begin
      sel_s = SEL_REDIR;
    end else if (pend_valid_s) begin
      sel_s = SEL_PEND;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next fetch address for the selected source.
  always_comb begin
    pc_next_s = pc_plus4_s;
    case (sel_s)
      SEL_EXC:   pc_next_s = EXC_VEC;
      SEL_HOLD:  pc_next_s = pc_r;
      SEL_REDIR: pc_next_s = rsel_s;
      SEL_PEND:  pc_next_s = pend_target_s;
      SEL_SEQ:   pc_next_s = pc_plus4_s;
      default:   pc_next_s = pc_plus4_s;
    endcase
  end

  assign load_s     = (sel_s == SEL_HOLD) & rvalid_s;
  assign clear_s    = (sel_s == SEL_EXC) | (sel_s == SEL_REDIR);
  assign consume_s  = (sel_s == SEL_PEND);
  assign next_bad_s = addr_bad(pc_next_s);

  pc_redirect_buf #(.W(W)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .clear       (clear_s),
    .consume     (consume_s),
    .load_target (rsel_s),
    .pend_valid  (pend_valid_s),
    .pend_target (pend_target_s)
  );

  // Link value and AdEL status are registered alongside pc so they always track it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r        <= RESET_VEC;
      pc_plus8_r  <= RESET_VEC + STEP8;
      fetch_exc_r <= addr_bad(RESET_VEC);
      exc_code_r  <= addr_bad(RESET_VEC) ? EXC_ADEL : EXC_NONE;
    end else begin
      pc_r        <= pc_next_s;
      pc_plus8_r  <= pc_next_s + STEP8;
      fetch_exc_r <= next_bad_s;
      exc_code_r  <= next_bad_s ? EXC_ADEL : EXC_NONE;
    end
  end

  assign pc         = pc_r;
  assign pc_plus8   = pc_plus8_r;
  assign pend_valid = pend_valid_s;
  assign fetch_exc  = fetch_exc_r;
  assign exc_code   = exc_code_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural model of the PC sequencing rules.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret, br_valid;
  logic [31:0] epc, br_target;
  logic [31:0] pc, pc_plus8;
  logic        pend_valid, fetch_exc;
  logic [4:0]  exc_code;

  logic        w_reset;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic [31:0] w_pc, w_pc_plus8;
  logic        w_pend_valid, w_fetch_exc;
  logic [4:0]  w_exc_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pt;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .br_valid(br_valid), .br_target(br_target), .pc(pc), .pc_plus8(pc_plus8),
    .pend_valid(pend_valid), .fetch_exc(fetch_exc), .exc_code(exc_code)
  );

  pc_unit #(.W(32), .RESET_VEC(32'hFFFF_FFF8), .IM_HI(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(w_reset), .stall(w_zero), .req(w_zero), .eret(w_zero), .epc(w_zero32),
    .br_valid(w_zero), .br_target(w_zero32), .pc(w_pc), .pc_plus8(w_pc_plus8),
    .pend_valid(w_pend_valid), .fetch_exc(w_fetch_exc), .exc_code(w_exc_code)
  );

  function automatic logic m_bad(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic cycle();
    if (reset) begin
      m_pc = 32'h0000_3000; m_pv = 1'b0; m_pt = 32'h0;
    end else if (req) begin
      m_pc = 32'h0000_4180; m_pv = 1'b0;
    end else if (stall) begin
      if (eret || br_valid) begin
        m_pt = eret ? epc : br_target; m_pv = 1'b1;
      end
    end else if (eret || br_valid) begin
      m_pc = eret ? epc : br_target; m_pv = 1'b0;
    end else if (m_pv) begin
      m_pc = m_pt; m_pv = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0; br_valid = 1'b0;
    epc = 32'h0; br_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0000_3000); end
    n_checks++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b exp 0", pend_valid); end
    n_checks++; if (pc_plus8 !== 32'h0000_3008) begin n_fail++; $display("FAIL reset_plus8 got %h exp %h", pc_plus8, 32'h0000_3008); end
    n_checks++; if (fetch_exc !== 1'b0 || exc_code !== 5'd0) begin n_fail++; $display("FAIL reset_exc got %b/%0d exp 0/0", fetch_exc, exc_code); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h0000_3004; exp_seq[1] = 32'h0000_3008; exp_seq[2] = 32'h0000_300C;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (pc !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_seq[i]); end
    end
    n_checks++; if (pc_plus8 !== 32'h0000_3014) begin n_fail++; $display("FAIL seq_plus8 got %h exp %h", pc_plus8, 32'h0000_3014); end
  endtask

  task automatic test_stall_branch();
    cycle();
    n_checks++; if (pc !== 32'h0000_3010) begin n_fail++; $display("FAIL stall_start got %h exp %h", pc, 32'h0000_3010); end
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
    cycle();
    br_valid = 1'b0;
    n_checks++; if (pc !== 32'h0000_3010 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold1 got %h/%b exp 3010/1", pc, pend_valid); end
    cycle();
    n_checks++; if (pc !== 32'h0000_3010 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold2 got %h/%b exp 3010/1", pc, pend_valid); end
    stall = 1'b0;
    cycle();
    n_checks++; if (pc !== 32'h0000_3100 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got %h/%b exp 3100/0", pc, pend_valid); end
  endtask

  task automatic test_newer_redirect();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3100;
    cycle();
    br_valid = 1'b0; eret = 1'b1; epc = 32'h0000_3200;
    cycle();
    eret = 1'b0; stall = 1'b0;
    cycle();
    n_checks++; if (pc !== 32'h0000_3200 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL newer_redirect got %h/%b exp 3200/0", pc, pend_valid); end
  endtask

  task automatic test_req_over_pending();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3300;
    cycle();
    br_valid = 1'b0;
    n_checks++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL req_setup_pend got %b exp 1", pend_valid); end
    req = 1'b1;
    cycle();
    req = 1'b0; stall = 1'b0;
    n_checks++; if (pc !== 32'h0000_4180 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL req_vector got %h/%b exp 4180/0", pc, pend_valid); end
    eret = 1'b1; epc = 32'h0000_3008;
    cycle();
    eret = 1'b0;
    n_checks++; if (pc !== 32'h0000_3008) begin n_fail++; $display("FAIL req_eret got %h exp %h", pc, 32'h0000_3008); end
  endtask

  task automatic test_same_cycle();
    req = 1'b1; eret = 1'b1; epc = 32'h0000_3500;
    cycle();
    req = 1'b0;
    n_checks++; if (pc !== 32'h0000_4180) begin n_fail++; $display("FAIL req_beats_eret got %h exp %h", pc, 32'h0000_4180); end
    br_valid = 1'b1; br_target = 32'h0000_3600;
    cycle();
    eret = 1'b0; br_valid = 1'b0;
    n_checks++; if (pc !== 32'h0000_3500) begin n_fail++; $display("FAIL eret_beats_br got %h exp %h", pc, 32'h0000_3500); end
  endtask

  task automatic test_fetch_exc();
    logic [31:0] tgt [2];
    tgt[0] = 32'h0000_3102; tgt[1] = 32'h0000_7000;
    for (int i = 0; i < 2; i++) begin
      br_valid = 1'b1; br_target = tgt[i];
      cycle();
      br_valid = 1'b0;
      n_checks++; if (pc !== tgt[i] || fetch_exc !== 1'b1 || exc_code !== 5'd4) begin n_fail++; $display("FAIL adel[%0d] got %h/%b/%0d exp %h/1/4", i, pc, fetch_exc, exc_code, tgt[i]); end
      cycle();
      n_checks++; if (pc !== tgt[i] + 32'd4 || fetch_exc !== 1'b1) begin n_fail++; $display("FAIL adel_seq[%0d] got %h/%b exp %h/1", i, pc, fetch_exc, tgt[i] + 32'd4); end
    end
    stall = 1'b1;
    cycle();
    stall = 1'b0;
    n_checks++; if (pc !== 32'h0000_7004 || fetch_exc !== 1'b1 || exc_code !== 5'd4) begin n_fail++; $display("FAIL adel_stalled got %h/%b/%0d exp 7004/1/4", pc, fetch_exc, exc_code); end
    br_valid = 1'b1; br_target = 32'h0000_6FFC;
    cycle();
    br_valid = 1'b0;
    n_checks++; if (fetch_exc !== 1'b0 || exc_code !== 5'd0) begin n_fail++; $display("FAIL im_hi_edge got %b/%0d exp 0/0", fetch_exc, exc_code); end
    cycle();
    n_checks++; if (pc !== 32'h0000_7000 || fetch_exc !== 1'b1) begin n_fail++; $display("FAIL past_im_hi got %h/%b exp 7000/1", pc, fetch_exc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_p8 [3];
    logic        exp_ex [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_p8[0] = 32'h0000_0000; exp_ex[0] = 1'b0;
    exp_pc[1] = 32'hFFFF_FFFC; exp_p8[1] = 32'h0000_0004; exp_ex[1] = 1'b0;
    exp_pc[2] = 32'h0000_0000; exp_p8[2] = 32'h0000_0008; exp_ex[2] = 1'b1;
    w_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (w_pc !== exp_pc[i] || w_pc_plus8 !== exp_p8[i] || w_fetch_exc !== exp_ex[i] ||
          w_exc_code !== (exp_ex[i] ? 5'd4 : 5'd0) || w_pend_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap[%0d] got pc=%h p8=%h exc=%b code=%0d exp pc=%h p8=%h exc=%b",
                 i, w_pc, w_pc_plus8, w_fetch_exc, w_exc_code, exp_pc[i], exp_p8[i], exp_ex[i]);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      req       = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      eret      = ($urandom_range(0, 9) == 0);
      br_valid  = ($urandom_range(0, 4) == 0);
      epc       = 32'h0000_3000 + {$urandom_range(0, 4200), 2'b00};
      br_target = 32'h0000_3000 + {$urandom_range(0, 4200), 2'b00};
      if ($urandom_range(0, 7) == 0) br_target = br_target | 32'h2;
      cycle();
      n_checks++;
      if (pc !== m_pc || pend_valid !== m_pv || pc_plus8 !== m_pc + 32'd8 ||
          fetch_exc !== m_bad(m_pc) || exc_code !== (m_bad(m_pc) ? 5'd4 : 5'd0)) begin
        n_fail++;
        $display("FAIL random[%0d] got pc=%h pv=%b p8=%h exc=%b code=%0d exp pc=%h pv=%b",
                 i, pc, pend_valid, pc_plus8, fetch_exc, exc_code, m_pc, m_pv);
      end
    end
    idle_inputs();
  endtask

  initial begin
    w_reset = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall_branch();
    test_newer_redirect();
    test_req_over_pending();
    test_same_cycle();
    test_fetch_exc();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch-address register for the pipelined MIPS core. Successor to the fixed 32-bit PC.
- Sequences the PC (sequential +4), branch/jump redirects, the exception vector and ERET return to EPC.
- Buffers a redirect that arrives during a stall so it is not lost; flags fetch address exceptions (AdEL).
- Sits at the head of the F stage and drives the IM address and F/D pipeline register.

Parameters:
- W, 32, address width in bits.
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard stall from D stage; holds PC.
- req  in  1  exception/interrupt taken; redirect to EXC_VEC.
- eret  in  1  ERET in D stage; return to epc.
- epc  in  W  return address from CP0.
- br_valid  in  1  taken branch/jump from D stage.
- br_target  in  W  branch/jump target.
- pc  out  W  current fetch address.
- pc_plus8  out  W  pc+8 link value (mod 2^W).
- pend_valid  out  1  a buffered redirect is waiting.
- fetch_exc  out  1  current pc is misaligned or outside [IM_LO, IM_HI].
- exc_code  out  5  5'd4 (AdEL) when fetch_exc, else 5'd0.

Behaviour:
- Synchronous reset, clk domain only.
- Reset values: pc = RESET_VEC; pend_valid = 0; pending target = 0.
- Redirect source this cycle: rsel = eret ? epc : br_target; rvalid = eret | br_valid. ERET beats branch on the same cycle.
- Next-state priority, evaluated each rising edge:
  1. reset: as above.
  2. req: pc <= EXC_VEC; pend_valid <= 0. Overrides stall, pending and rvalid.
  3. stall and rvalid: pc holds; pending <= rsel; pend_valid <= 1. A newer redirect overwrites an older pending one.
  4. stall, no rvalid: pc and pending hold.
  5. no stall and rvalid: pc <= rsel; pend_valid <= 0. A fresh redirect beats the pending one.
  6. no stall and pend_valid: pc <= pending; pend_valid <= 0.
  7. otherwise: pc <= pc + 4, mod 2^W.
- Latency: a redirect presented in a non-stalled cycle appears on pc the next cycle. If it was buffered during a stall, it appears on pc the cycle after stall deasserts.
- Wrap-around: pc + 4 and pc + 8 truncate to W bits; no overflow flag.
- fetch_exc is combinational from the pc register: (pc[1:0] != 0) | (pc < IM_LO) | (pc > IM_HI), with unsigned compares.
  - Does not alter sequencing; the downstream pipeline substitutes a NOP and reports AdEL to CP0.
  - Is asserted even while stalled.
- Reset mid-stall or while pending: reset wins; pending is discarded.
- req and eret in the same cycle: req wins; the eret is dropped.

Decomposition:
- Shared package mips_pkg:
  - EXC_ADEL = 5'd4, EXC_NONE = 5'd0.
  - Default RESET_VEC, EXC_VEC, IM_LO, IM_HI constants.
  - INSN_BYTES = 4.
- One sub-module is natural: pc_redirect_buf. It holds the pending target and valid bit, with load/clear/consume controls. pc_unit owns the priority mux, the adders and the range check.

Test Plan:
- Reset, then 3 cycles free-running, no stall -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus8 = 0x3014 at the last step.
- At pc = 0x3010: br_valid = 1, br_target = 0x3100 with stall = 1 for 2 cycles, then stall = 0 -> pc holds 0x3010, pend_valid = 1; the cycle after release pc = 0x3100 and pend_valid = 0.
- During a stall: br_target 0x3100, then eret with epc = 0x3200 the next cycle; release -> pc = 0x3200 (the newer redirect wins).
- req = 1 asserted together with stall = 1 and pend_valid = 1 -> next pc = 0x4180, pend_valid = 0. Then eret with epc = 0x3008 -> pc = 0x3008.
- br_target = 0x3102, then separately 0x7000 -> fetch_exc = 1 and exc_code = 4 in each case. pc keeps sequencing: 0x3106 and 0x7004 respectively.
- W = 32 with RESET_VEC = 0xFFFF_FFF8, IM_HI = 0xFFFF_FFFC -> pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. fetch_exc rises at 0x0 because it is below IM_LO.
